trace_event_tx: RTL
===================

TRACE_EVENT_TX -- requirements
Module: trace_event_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter TERM_CODE, default 16'h0001, l.nop immediate that signals program exit.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_sys  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  writeback stage valid (not frozen).
REQ-006 SHALL have port wb_pc  input  32  retiring instruction address (unused for events; held for debug).
REQ-007 SHALL have port wb_insn  input  32  retiring instruction word.
REQ-008 SHALL have port r3  input  32  GPR r3 value at retirement.
REQ-009 SHALL have port out_flit  output  16  outgoing trace flit.
REQ-010 SHALL have port out_valid  output  1  out_flit valid.
REQ-011 SHALL have port out_last  output  1  marks final flit of a packet.
REQ-012 SHALL have port out_ready  input  1  downstream accepts flit.
REQ-013 SHALL have port terminated  output  1  sticky exit seen.
REQ-014 SHALL have port drop_cnt  output  16  events lost to full buffer.

Function
REQ-015 Event SHALL be detected when enable=1, wb_insn[31:24]=8'h15 (l.nop) and K=wb_insn[15:0] != 0.
REQ-016 On detection with terminated=0 and buffer not full, record {K, r3} SHALL be written at that clock edge.
REQ-017 Detected event with buffer full SHALL be dropped and drop_cnt incremented, saturating at 16'hFFFF.
REQ-018 Full SHALL be evaluated before any same-cycle pop; push on full SHALL drop even if a pop completes that cycle.
REQ-019 Event with K=TERM_CODE SHALL be buffered (if room) and set terminated at the same edge; while terminated=1 no further events SHALL be detected or counted.
REQ-020 Transmit FSM states: IDLE, HDR, D_HI, D_LO; IDLE->HDR when buffer non-empty.
REQ-021 HDR drives K, D_HI drives r3[31:16], D_LO drives r3[15:0]; out_last=1 only on final flit state.
REQ-022 Each state SHALL advance only on out_valid & out_ready; out_flit/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Buffer entry SHALL be popped on final-flit handshake; FSM SHALL go to HDR if buffer still non-empty, else IDLE (back-to-back packets, no idle cycle).
REQ-024 out_valid SHALL be 1 exactly in non-IDLE states; first out_valid earliest one cycle after event edge.
REQ-025 Buffer SHALL be FIFO-ordered; pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 rst_sys=1 at a clock edge SHALL set FSM IDLE, buffer empty, out_valid=0, out_last=0, out_flit=0, terminated=0, drop_cnt=0, timestamp=0.
REQ-027 Reset mid-packet SHALL abandon the packet; no partial-packet continuation after reset release.
REQ-028 Events presented in the reset cycle SHALL be ignored.

Configuration
REQ-029 Macro TRACE_EVENT_TIMESTAMP_EN SHALL enable a 32-bit free-running cycle counter (reset 0, wraps) captured with each event.
REQ-030 With TRACE_EVENT_TIMESTAMP_EN defined, FSM SHALL insert states T_HI, T_LO after D_LO (6-flit packet, out_last on T_LO); without it packets are 3 flits, no counter exists.

Verification
REQ-031 Single event: insn 32'h15000004, r3 32'h00000041, enable=1, out_ready=1 -> flits 16'h0004, 16'h0000, 16'h0041, out_last on third, then IDLE.
REQ-032 Backpressure: out_ready=0 for 5 cycles during D_HI -> out_flit held 16'h0000, valid stays 1, no flit lost or duplicated.
REQ-033 Overflow: FIFO_DEPTH=4, out_ready=0, 6 consecutive events -> 4 buffered, drop_cnt=2; release ready -> 4 packets in order.
REQ-034 Exit: insn 32'h15000001 then 32'h15000004 -> terminated=1 after first, second not buffered nor counted, exit packet transmitted.
REQ-035 Reset mid-packet: assert rst_sys during D_HI -> next cycle out_valid=0, drop_cnt=0, terminated=0; new event transmits from HDR.
REQ-036 Non-event: insn 32'h15000000 or enable=0 with 32'h15000004 -> no packet, drop_cnt unchanged.

Source files
------------

// File: rtl/trace_event_tx_if.sv
// Trace flit stream between trace_event_tx (master) and its downstream consumer (slave).
// A flit transfers on a rising edge where out_valid=1 and out_ready=1. Once out_valid rises,
// out_flit and out_last hold until that transfer, and out_valid never drops without one.
interface trace_event_tx_if;
  logic [15:0] out_flit;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output out_flit,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_flit,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/trace_event_tx.sv
// Captures l.nop trace events {K, r3} at writeback into a small FIFO and streams each as a flit packet.
// Define TRACE_EVENT_TIMESTAMP_EN to append a 32-bit cycle timestamp (6-flit packets instead of 3).
module trace_event_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] TERM_CODE  = 16'h0001
) (
  input  logic                    clk,
  input  logic                    rst_sys,
  input  logic                    enable,
  input  logic [31:0]             wb_pc,
  input  logic [31:0]             wb_insn,
  input  logic [31:0]             r3,
  trace_event_tx_if.master        tx,
  output logic                    terminated,
  output logic [15:0]             drop_cnt,
  output logic [2:0]              dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_D_HI = 3'd2,
    S_D_LO = 3'd3,
    S_T_HI = 3'd4,
    S_T_LO = 3'd5
  } state_e;

`ifdef TRACE_EVENT_TIMESTAMP_EN
  localparam state_e LAST_S = S_T_LO;
`else
  localparam state_e LAST_S = S_D_LO;
`endif

  typedef struct packed {
    logic [15:0] k;
    logic [31:0] data;
`ifdef TRACE_EVENT_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } rec_t;

  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [CW-1:0] count_q;
  logic          term_q;
  logic [15:0]   drop_q;

  state_e        state_q;
  logic [15:0]   flit_q;
  logic          valid_q;
  logic          last_q;

  logic          detect, full, push, drop, pop, hs, next_avail;
  rec_t          push_rec, head_rec, next_rec;

  // wb_pc and the middle opcode bits carry nothing an event needs
  logic unused_ok;
  assign unused_ok = ^{wb_pc, wb_insn[23:16]};

`ifdef TRACE_EVENT_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk) begin
    if (rst_sys) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end
`endif

  assign hs     = valid_q && tx.out_ready;
  assign detect = enable && (wb_insn[31:24] == 8'h15) && (wb_insn[15:0] != 16'h0000) && !term_q;
  // full is taken from the registered count, so a pop in the same cycle cannot make room
  assign full   = (count_q == DEPTH_C);
  assign push   = detect && !full;
  assign drop   = detect && full;
  assign pop    = hs && (state_q == LAST_S);

  always_comb begin
    push_rec      = '0;
    push_rec.k    = wb_insn[15:0];
    push_rec.data = r3;
`ifdef TRACE_EVENT_TIMESTAMP_EN
    push_rec.ts   = ts_q;
`endif
  end

  assign rd_ptr_inc = rd_ptr_q + AW'(1);
  assign head_rec   = mem_q[rd_ptr_q];
  // After the final flit, the next packet is either already queued or being pushed right now
  assign next_avail = (count_q > CW'(1)) || push;
  assign next_rec   = (count_q > CW'(1)) ? mem_q[rd_ptr_inc] : push_rec;

  always_ff @(posedge clk) begin
    if (push && !rst_sys) mem_q[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      term_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_inc;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (detect && (wb_insn[15:0] == TERM_CODE)) term_q <= 1'b1;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  function automatic state_e succ(input state_e s);
    case (s)
      S_HDR:   return S_D_HI;
      S_D_HI:  return S_D_LO;
      S_D_LO:  return S_T_HI;
      S_T_HI:  return S_T_LO;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [15:0] flit_of(input state_e s, input rec_t r);
    case (s)
      S_HDR:   return r.k;
      S_D_HI:  return r.data[31:16];
      S_D_LO:  return r.data[15:0];
`ifdef TRACE_EVENT_TIMESTAMP_EN
      S_T_HI:  return r.ts[31:16];
      S_T_LO:  return r.ts[15:0];
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Outputs are registered: each transition loads the flit belonging to the state being entered
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      flit_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_HDR;
            valid_q <= 1'b1;
            flit_q  <= head_rec.k;
            last_q  <= 1'b0;
          end
        end
        default: begin
          if (hs) begin
            if (state_q == LAST_S) begin
              if (next_avail) begin
                state_q <= S_HDR;
                valid_q <= 1'b1;
                flit_q  <= next_rec.k;
                last_q  <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                flit_q  <= '0;
                last_q  <= 1'b0;
              end
            end else begin
              state_q <= succ(state_q);
              flit_q  <= flit_of(succ(state_q), head_rec);
              last_q  <= (succ(state_q) == LAST_S);
            end
          end
        end
      endcase
    end
  end

  assign tx.out_flit  = flit_q;
  assign tx.out_valid = valid_q;
  assign tx.out_last  = last_q;
  assign terminated   = term_q;
  assign drop_cnt     = drop_q;
  assign dbg_state_o  = state_q;

endmodule
